// File: rtl/dmni_br_tx.sv
// BrLite transmit side of the DMNI: MMR-staged broadcast words are queued and sent over a four-phase req/ack handshake.
// br_req_o rises 1 cycle after the FIFO becomes non-empty; pushes to a full FIFO are dropped and flagged as overflow.
module dmni_br_tx #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  address_i,
    input  logic        cfg_en_i,
    input  logic        cfg_we_i,
    input  logic [7:0]  cfg_addr_i,
    input  logic [31:0] cfg_data_i,
    output logic [31:0] cfg_data_o,
    output logic        br_req_o,
    input  logic        br_ack_i,
    output logic [35:0] br_data_o,
    output logic        irq_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [7:0] ADDR_STATUS  = 8'h00;
    localparam logic [7:0] ADDR_TX      = 8'h40;
    localparam logic [7:0] ADDR_PAYLOAD = 8'h44;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RELEASE
    } state_t;

    state_t             state_q, state_d;
    logic [35:0]        mem_q [FIFO_DEPTH];
    logic [35:0]        mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [7:0]         seq_q, seq_d;
    logic [15:0]        payload_q, payload_d;
    logic               irq_en_q, irq_en_d;
    logic               ovf_q, ovf_d;
    logic [31:0]        cfg_data_q, cfg_data_d;
    logic               br_req_q, br_req_d;
    logic [35:0]        br_data_q, br_data_d;

    logic               wr_en;
    logic               rd_en;
    logic               push_req;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    logic               busy;
    logic [3:0]         cnt4;
    logic [31:0]        status_w;
    logic               unused_cfg_bits;

    assign unused_cfg_bits = ^cfg_data_i[31:16];

    assign wr_en    = cfg_en_i & cfg_we_i;
    assign rd_en    = cfg_en_i & ~cfg_we_i;
    assign full     = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    // Full is judged on the current count, so a same-cycle pop never makes room for a push.
    assign push_req = wr_en && (cfg_addr_i == ADDR_TX);
    assign push     = push_req && !full;
    assign busy     = !empty || (state_q != ST_IDLE);
    assign cnt4     = 4'(count_q);
    assign status_w = {24'h0, cnt4, irq_en_q, ovf_q, full, busy};

    always_comb begin
        state_d   = state_q;
        br_req_d  = br_req_q;
        br_data_d = br_data_q;
        pop       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    state_d   = ST_REQ;
                    br_req_d  = 1'b1;
                    br_data_d = mem_q[rd_ptr_q];
                end
            end
            ST_REQ: begin
                if (br_ack_i) begin
                    pop      = 1'b1;
                    br_req_d = 1'b0;
                    state_d  = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!br_ack_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = {payload_q, seq_q, address_i, cfg_data_i[3:0]};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        payload_d  = payload_q;
        seq_d      = seq_q;
        irq_en_d   = irq_en_q;
        ovf_d      = ovf_q;
        cfg_data_d = cfg_data_q;
        if (wr_en && (cfg_addr_i == ADDR_PAYLOAD)) begin
            payload_d = cfg_data_i[15:0];
        end
        if (push) begin
            seq_d = seq_q + 8'd1;
        end
        if (push_req && full) begin
            ovf_d = 1'b1;
        end
        if (wr_en && (cfg_addr_i == ADDR_STATUS)) begin
            irq_en_d = cfg_data_i[3];
            if (cfg_data_i[2]) begin
                ovf_d = 1'b0;
            end
        end
        if (rd_en) begin
            case (cfg_addr_i)
                ADDR_STATUS:  cfg_data_d = status_w;
                ADDR_TX:      cfg_data_d = {24'h0, seq_q};
                ADDR_PAYLOAD: cfg_data_d = {16'h0, payload_q};
                default:      cfg_data_d = 32'h0;
            endcase
        end
    end

    // Queue storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            seq_q      <= '0;
            payload_q  <= '0;
            irq_en_q   <= 1'b0;
            ovf_q      <= 1'b0;
            cfg_data_q <= '0;
            br_req_q   <= 1'b0;
            br_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            seq_q      <= seq_d;
            payload_q  <= payload_d;
            irq_en_q   <= irq_en_d;
            ovf_q      <= ovf_d;
            cfg_data_q <= cfg_data_d;
            br_req_q   <= br_req_d;
            br_data_q  <= br_data_d;
        end
    end

    assign cfg_data_o = cfg_data_q;
    assign br_req_o   = br_req_q;
    assign br_data_o  = br_data_q;
    assign irq_o      = irq_en_q && !full;

endmodule
